// File: rtl/sram_pkg.sv
// Shared levels, FSM state encoding and level helper for the SRAM array controller.
package sram_pkg;

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_SETUP = 3'd1,
        WR_PULSE = 3'd2,
        WR_REC   = 3'd3,
        RD_PULSE = 3'd4,
        RD_REC   = 3'd5,
        RESP     = 3'd6
    } sram_state_e;

    function automatic real lvl(input bit b);
        return b ? VDD : VSS;
    endfunction

endpackage

// File: rtl/sram_level_drv.sv
// Converts a per-bit enable vector into an array of analog drive levels (VDD/VSS).
module sram_level_drv
    import sram_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [N-1:0] en,
    output real          lvl_out [N]
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign lvl_out[i] = lvl(en[i]);
    end

endmodule

// File: rtl/sram_array_ctrl.sv
// Cycle-exact initiator for the SRAM cell_array / sense_amp pair.
// Optional write-verify readback is enabled by defining SRAM_WRITE_VERIFY_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | req_ready high, waiting for a request
// WR_SETUP | write bitlines driven from captured data, wordlines low
// WR_PULSE | write wordline of the captured row high for WL_CYC cycles
// WR_REC   | write wordline low, bitlines held for REC_CYC cycles
// RD_PULSE | read wordline high for WL_CYC cycles, sense sampled on last edge
// RD_REC   | read wordline low for REC_CYC cycles
// RESP     | one-cycle response strobe, bitlines released
module sram_array_ctrl
    import sram_pkg::*;
#(
    parameter  int ROWS    = 1,
    parameter  int COLS    = 1,
    parameter  int WL_CYC  = 10,
    parameter  int REC_CYC = 10,
    localparam int AW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [COLS-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [COLS-1:0] rsp_rdata,
    output logic            rsp_err,
    output real             row_wr  [ROWS],
    output real             row_rd  [ROWS],
    output real             bl_wr   [COLS],
    output real             blb_wr  [COLS],
    input  real             preout  [COLS]
);

`ifdef SRAM_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    localparam int            MAXC     = (WL_CYC > REC_CYC) ? WL_CYC : REC_CYC;
    localparam int            CW       = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] WL_LOAD  = CW'(WL_CYC - 1);
    localparam logic [CW-1:0] REC_LOAD = CW'(REC_CYC - 1);

    sram_state_e     state;
    logic [CW-1:0]   cnt;
    logic            cnt_tc;
    logic [ROWS-1:0] req_sel;
    logic [ROWS-1:0] cap_row;
    logic            cap_we;
    logic [COLS-1:0] cap_wdata;
    logic [COLS-1:0] rd_data;
    logic [COLS-1:0] sense_bits;
    logic [ROWS-1:0] row_wr_en;
    logic [ROWS-1:0] row_rd_en;
    logic [COLS-1:0] bl_en;
    logic [COLS-1:0] blb_en;

    assign cnt_tc = (cnt == '0);

    // An out-of-range address decodes to an all-zero row select, so no wordline ever rises.
    always_comb begin
        req_sel = '0;
        for (int r = 0; r < ROWS; r++) begin
            req_sel[r] = (req_addr == AW'(r));
        end
    end

    always_comb begin
        sense_bits = '0;
        for (int c = 0; c < COLS; c++) begin
            sense_bits[c] = (preout[c] >= VTH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_row   <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
            rd_data   <= '0;
            row_wr_en <= '0;
            row_rd_en <= '0;
            bl_en     <= '0;
            blb_en    <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        cap_row   <= req_sel;
                        cap_we    <= req_we;
                        cap_wdata <= req_wdata;
                        if (req_we) begin
                            bl_en  <= req_wdata;
                            blb_en <= ~req_wdata;
                            state  <= WR_SETUP;
                        end else begin
                            row_rd_en <= req_sel;
                            cnt       <= WL_LOAD;
                            state     <= RD_PULSE;
                        end
                    end
                end
                WR_SETUP: begin
                    row_wr_en <= cap_row;
                    cnt       <= WL_LOAD;
                    state     <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt_tc) begin
                        row_wr_en <= '0;
                        cnt       <= REC_LOAD;
                        state     <= WR_REC;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_REC: begin
                    if (cnt_tc) begin
                        bl_en  <= '0;
                        blb_en <= '0;
                        if (VERIFY && (cap_row != '0)) begin
                            row_rd_en <= cap_row;
                            cnt       <= WL_LOAD;
                            state     <= RD_PULSE;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_err   <= (cap_row == '0);
                            state     <= RESP;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RD_PULSE: begin
                    if (cnt_tc) begin
                        rd_data   <= sense_bits;
                        row_rd_en <= '0;
                        cnt       <= REC_LOAD;
                        state     <= RD_REC;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RD_REC: begin
                    if (cnt_tc) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                        if (cap_row == '0) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                        end else begin
                            rsp_rdata <= rd_data;
                            rsp_err   <= cap_we && (rd_data != cap_wdata);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sram_level_drv #(.N(ROWS)) u_row_wr (.en(row_wr_en), .lvl_out(row_wr));
    sram_level_drv #(.N(ROWS)) u_row_rd (.en(row_rd_en), .lvl_out(row_rd));
    sram_level_drv #(.N(COLS)) u_bl_wr  (.en(bl_en),     .lvl_out(bl_wr));
    sram_level_drv #(.N(COLS)) u_blb_wr (.en(blb_en),    .lvl_out(blb_wr));

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Scoreboard bench for sram_array_ctrl with a behavioural cell-array / sense-amp model.
`timescale 1ns/1ps
module tb_sram_array_ctrl;
    import sram_pkg::*;

    localparam int ROWS = 3;
    localparam int COLS = 8;
    localparam int AW   = 2;
`ifdef SRAM_WRITE_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [COLS-1:0] req_wdata = '0;
    logic            rsp_valid;
    logic [COLS-1:0] rsp_rdata;
    logic            rsp_err;
    real             row_wr [ROWS];
    real             row_rd [ROWS];
    real             bl_wr  [COLS];
    real             blb_wr [COLS];
    real             preout [COLS];

    sram_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .WL_CYC(10), .REC_CYC(10)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .row_wr(row_wr), .row_rd(row_rd), .bl_wr(bl_wr), .blb_wr(blb_wr), .preout(preout)
    );

    always #5 clk = ~clk;

    // Cell array + sense amp model
    logic [COLS-1:0] mem [ROWS];
    bit  force0  = 1'b0;
    bit  ovr_en  = 1'b0;
    real ovr_lvl = 0.0;

    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++)
            if (row_wr[r] >= VTH)
                for (int c = 0; c < COLS; c++) mem[r][c] <= (bl_wr[c] >= VTH);
    end

    always_comb begin
        for (int c = 0; c < COLS; c++) preout[c] = VSS;
        for (int r = 0; r < ROWS; r++)
            if (row_rd[r] >= VTH)
                for (int c = 0; c < COLS; c++) preout[c] = mem[r][c] ? VDD : VSS;
        if (force0) for (int c = 0; c < COLS; c++) preout[c] = VSS;
        if (ovr_en) for (int c = 0; c < COLS; c++) preout[c] = ovr_lvl;
    end

    int cyc = 0;
    int acc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) acc <= acc + 1;
    end

    typedef struct {
        logic [COLS-1:0] rdata;
        logic            err;
        int              cyc;
        int              wr_hi;
        int              rd_hi;
        int              row;
        logic            we;
        logic [COLS-1:0] wdata;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int wr_hi = 0;
    int rd_hi = 0;
    int excl_viol = 0;
    int stray = 0;
    int bl_viol = 0;

    task automatic check(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_r(input string name, input real got, input real exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %f expected %f (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        int nwr, nrd;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                nwr = 0;
                nrd = 0;
                for (int r = 0; r < ROWS; r++) begin
                    if (row_wr[r] >= VTH) nwr++;
                    if (row_rd[r] >= VTH) nrd++;
                    if ((row_wr[r] >= VTH || row_rd[r] >= VTH) && (sb.size() == 0 || sb[0].row != r))
                        stray++;
                end
                if (nwr + nrd > 1) excl_viol++;
                if (nwr > 0 && sb.size() > 0 && sb[0].we)
                    for (int c = 0; c < COLS; c++)
                        if ((bl_wr[c] >= VTH) != sb[0].wdata[c] || (blb_wr[c] >= VTH) == sb[0].wdata[c])
                            bl_viol++;
                wr_hi += nwr;
                rd_hi += nrd;
                if (rsp_valid) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_rsp: rsp_valid with empty scoreboard (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_cycle", longint'(cyc), longint'(e.cyc));
                        check("rsp_rdata", longint'(rsp_rdata), longint'(e.rdata));
                        check("rsp_err", longint'(rsp_err), longint'(e.err));
                        check("wr_pulse_len", longint'(wr_hi), longint'(e.wr_hi));
                        check("rd_pulse_len", longint'(rd_hi), longint'(e.rd_hi));
                    end
                    wr_hi = 0;
                    rd_hi = 0;
                end
            end
        end
    endtask

    task automatic push_exp(input logic we, input int addr, input logic [COLS-1:0] wd,
                            input logic [COLS-1:0] erd, input logic eerr);
        exp_t e;
        bit inr;
        inr     = (addr < ROWS);
        e.rdata = erd;
        e.err   = eerr;
        e.we    = we;
        e.wdata = wd;
        e.row   = inr ? addr : -1;
        e.wr_hi = (we && inr) ? 10 : 0;
        e.rd_hi = (inr && (!we || VER)) ? 10 : 0;
        e.cyc   = cyc + (we ? ((VER && inr) ? 41 : 21) : 20);
        sb.push_back(e);
    endtask

    task automatic wait_ready_and_accept();
        int n;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", n);
            $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
            $fatal(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input int addr, input logic [COLS-1:0] wd,
                         input logic [COLS-1:0] erd, input logic eerr);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = AW'(addr);
        req_wdata = wd;
        wait_ready_and_accept();
        req_valid = 1'b0;
        push_exp(we, addr, wd, erd, eerr);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Write response data: readback when verifying, otherwise zero.
    function automatic logic [COLS-1:0] wr_rd(input logic [COLS-1:0] wd);
        return VER ? wd : '0;
    endfunction

    initial begin
        int acc0, n;
        fork
            monitor();
        join_none

        #12;
        check("rst_req_ready", longint'(req_ready), 0);
        check("rst_rsp_valid", longint'(rsp_valid), 0);
        check("rst_rsp_rdata", longint'(rsp_rdata), 0);
        check("rst_rsp_err", longint'(rsp_err), 0);
        check_r("rst_row_wr0", row_wr[0], VSS);
        check_r("rst_blb_wr0", blb_wr[0], VSS);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", longint'(req_ready), 1);

        // single-bit style write 1 / read / write 0 / read on row 0
        issue(1'b1, 0, 8'hFF, wr_rd(8'hFF), 1'b0);
        issue(1'b0, 0, 8'h00, 8'hFF, 1'b0);
        issue(1'b1, 0, 8'h00, wr_rd(8'h00), 1'b0);
        issue(1'b0, 0, 8'h00, 8'h00, 1'b0);

        // multi-row words
        issue(1'b1, 2, 8'hA5, wr_rd(8'hA5), 1'b0);
        issue(1'b1, 1, 8'h3C, wr_rd(8'h3C), 1'b0);
        issue(1'b0, 2, 8'h00, 8'hA5, 1'b0);
        issue(1'b0, 1, 8'h00, 8'h3C, 1'b0);

        // out-of-range address
        issue(1'b0, 3, 8'h00, 8'h00, 1'b1);
        issue(1'b1, 3, 8'hFF, 8'h00, 1'b1);
        drain();

        // req_valid held through busy: exactly one acceptance
        @(negedge clk);
        acc0      = acc;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 2'd3;
        wait_ready_and_accept();
        push_exp(1'b0, 3, 8'h00, 8'h00, 1'b1);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        drain();
        check("held_valid_accepts", longint'(acc - acc0), 1);

        // sense threshold boundary
        ovr_en  = 1'b1;
        ovr_lvl = VTH;
        issue(1'b0, 1, 8'h00, 8'hFF, 1'b0);
        drain();
        ovr_lvl = 0.79;
        issue(1'b0, 1, 8'h00, 8'h00, 1'b0);
        drain();
        ovr_en = 1'b0;

        // reset during WR_PULSE cycle 5
        issue(1'b1, 1, 8'h0F, 8'h00, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        check_r("pulse_before_reset", row_wr[1], VDD);
        rst_n = 1'b0;
        #1;
        check_r("reset_row_wr1", row_wr[1], VSS);
        check_r("reset_bl_wr0", bl_wr[0], VSS);
        check_r("reset_blb_wr7", blb_wr[7], VSS);
        check("reset_rsp_valid", longint'(rsp_valid), 0);
        sb.delete();
        wr_hi = 0;
        rd_hi = 0;
        #3;
        rst_n = 1'b1;
        check("ready_before_edge", longint'(req_ready), 0);
        @(posedge clk);
        #1;
        check("ready_edge_after_release", longint'(req_ready), 1);
        repeat (30) @(negedge clk);

        // post-reset operation on a clean row
        issue(1'b1, 0, 8'h96, wr_rd(8'h96), 1'b0);
        issue(1'b0, 0, 8'h00, 8'h96, 1'b0);
        drain();

`ifdef SRAM_WRITE_VERIFY_EN
        force0 = 1'b1;
        issue(1'b1, 0, 8'hFF, 8'h00, 1'b1);
        drain();
        force0 = 1'b0;
        issue(1'b1, 0, 8'h5A, 8'h5A, 1'b0);
        drain();
`endif

        check("wordline_exclusive", longint'(excl_viol), 0);
        check("only_addressed_row", longint'(stray), 0);
        check("bitlines_during_pulse", longint'(bl_viol), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
